// File: rtl/gpio_bus_turnaround_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_bus_turnaround_ctrl
//
// Sequences a shared half-duplex DDIO GPIO bus between one write requester
// and one read requester. Idle turnaround cycles (gpio_oe low) are inserted on
// every change of bus direction. Simultaneous requests are arbitrated
// round-robin. Read samples are tracked through an IN_LAT-deep strobe pipeline,
// so data returned from the GPIO input path comes back tagged valid.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_valid/wr_ready           write beat handshake (wr_ready = state is TX)
//   wr_data_hi/lo               rising/falling-edge data of a write beat
//   rd_req, rd_len              read request (level) and length (0 = 256)
//   rd_ack                      one-cycle pulse on read grant
//   rd_valid, rd_data_hi/lo     returned read beats
//   rd_done                     pulses together with the last rd_valid
//   gpio_oe, gpio_out_hi/lo     to the GPIO block oe / out_HI / out_LO
//   gpio_in_hi/lo               from the GPIO block in_HI / in_LO
//   busy                        FSM active or read pipeline not yet drained
//
// Timing: a read strobe is the clock edge that ends an RX cycle. The GPIO
// input path returns that sample IN_LAT edges later, at which edge it is
// registered into rd_data_* and rd_valid rises.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module gpio_bus_turnaround_ctrl #(
  parameter int BUS_WIDTH = 8,
  parameter int TA_CYCLES = 2,
  parameter int IN_LAT    = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [BUS_WIDTH-1:0] wr_data_hi,
  input  logic [BUS_WIDTH-1:0] wr_data_lo,
  input  logic                 rd_req,
  input  logic [7:0]           rd_len,
  output logic                 rd_ack,
  output logic                 rd_valid,
  output logic [BUS_WIDTH-1:0] rd_data_hi,
  output logic [BUS_WIDTH-1:0] rd_data_lo,
  output logic                 rd_done,
  output logic                 gpio_oe,
  output logic [BUS_WIDTH-1:0] gpio_out_hi,
  output logic [BUS_WIDTH-1:0] gpio_out_lo,
  input  logic [BUS_WIDTH-1:0] gpio_in_hi,
  input  logic [BUS_WIDTH-1:0] gpio_in_lo,
  output logic                 busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_TA, ST_TX, ST_RX} state_t;
  // Bus direction; also used as the grant type (TX = write, RX = read).
  typedef enum logic {DIR_RX = 1'b0, DIR_TX = 1'b1} dir_t;

  localparam logic [3:0] TA_LOAD   = 4'(TA_CYCLES);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t      state;
  dir_t        dir;
  dir_t        last_grant;
  dir_t        grant_dir;   // direction granted in IDLE, applied after TA
  logic [3:0]  ta_cnt;
  logic [7:0]  beat_cnt;
  logic [8:0]  rd_cnt;      // strobes still to issue for the current read
  logic [IN_LAT-1:0] stb_pipe;
  logic [IN_LAT-1:0] last_pipe;

  dir_t        arb_grant;
  logic        req_any;
  logic [7:0]  beat_next;
  logic        tx_exit;
  logic        stb_in;
  logic        last_in;
  logic        busy_fsm;
  logic        busy_next;

  assign wr_ready = (state == ST_TX);

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    req_any   = wr_valid | rd_req;
    arb_grant = DIR_RX;
    if (wr_valid && rd_req) begin
      arb_grant = (last_grant == DIR_TX) ? DIR_RX : DIR_TX;
    end else if (wr_valid) begin
      arb_grant = DIR_TX;
    end

    // Saturates so a long burst with no competing read cannot wrap.
    beat_next = (beat_cnt == BURST_MAX) ? beat_cnt : beat_cnt + 8'd1;
    // Checked on the accepting edge so the burst ends on exactly MAX_BURST.
    tx_exit   = !wr_valid || ((beat_next == BURST_MAX) && rd_req);

    stb_in    = (state == ST_RX);
    last_in   = (rd_cnt == 9'd1);

    // busy is registered, so it is computed from where the FSM goes next.
    busy_fsm = 1'b1;
    unique case (state)
      ST_IDLE: busy_fsm = req_any;
      ST_TA:   busy_fsm = 1'b1;
      ST_TX:   busy_fsm = !tx_exit;
      ST_RX:   busy_fsm = !last_in;
      default: busy_fsm = 1'b1;
    endcase
    busy_next = busy_fsm | stb_in | (|stb_pipe);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dir         <= DIR_RX;
      last_grant  <= DIR_RX;
      grant_dir   <= DIR_RX;
      ta_cnt      <= '0;
      beat_cnt    <= '0;
      rd_cnt      <= '0;
      // NOTE: the strobe pipeline is reset too; a stale strobe surviving
      // reset would emit a spurious rd_valid.
      stb_pipe    <= '0;
      last_pipe   <= '0;
      rd_ack      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_done     <= 1'b0;
      rd_data_hi  <= '0;
      rd_data_lo  <= '0;
      gpio_oe     <= 1'b0;
      gpio_out_hi <= '0;
      gpio_out_lo <= '0;
      busy        <= 1'b0;
    end else begin
      rd_ack <= 1'b0;
      busy   <= busy_next;

      // Read return path runs independently of the FSM so it can drain
      // while a following turnaround or write is already in progress.
      stb_pipe[0]  <= stb_in;
      last_pipe[0] <= stb_in & last_in;
      for (int i = 1; i < IN_LAT; i++) begin
        stb_pipe[i]  <= stb_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      rd_valid <= stb_pipe[IN_LAT-1];
      rd_done  <= stb_pipe[IN_LAT-1] & last_pipe[IN_LAT-1];
      if (stb_pipe[IN_LAT-1]) begin
        rd_data_hi <= gpio_in_hi;
        rd_data_lo <= gpio_in_lo;
      end

      unique case (state)
        ST_IDLE: begin
          if (req_any) begin
            grant_dir <= arb_grant;
            if (arb_grant == DIR_RX) begin
              rd_ack <= 1'b1;
              rd_cnt <= (rd_len == 8'd0) ? 9'd256 : {1'b0, rd_len};
            end
            if (arb_grant != dir) begin
              state   <= ST_TA;
              ta_cnt  <= TA_LOAD;
              gpio_oe <= 1'b0;
            end else begin
              state <= (arb_grant == DIR_TX) ? ST_TX : ST_RX;
            end
          end
        end

        ST_TA: begin
          // Leaving on a count of 1 gives exactly TA_CYCLES cycles in TA.
          if (ta_cnt <= 4'd1) begin
            ta_cnt <= '0;
            dir    <= grant_dir;
            state  <= (grant_dir == DIR_TX) ? ST_TX : ST_RX;
          end else begin
            ta_cnt <= ta_cnt - 4'd1;
          end
        end

        ST_TX: begin
          if (wr_valid) begin
            gpio_out_hi <= wr_data_hi;
            gpio_out_lo <= wr_data_lo;
            gpio_oe     <= 1'b1;
            beat_cnt    <= beat_next;
          end
          if (tx_exit) begin
            state      <= ST_IDLE;
            last_grant <= DIR_TX;
            beat_cnt   <= '0;
          end
        end

        ST_RX: begin
          rd_cnt <= rd_cnt - 9'd1;
          if (last_in) begin
            state      <= ST_IDLE;
            last_grant <= DIR_RX;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_turnaround_ctrl.sv
`timescale 1ns/1ps

module tb_gpio_bus_turnaround_ctrl;

  localparam int BW    = 8;
  localparam int TA    = 2;
  localparam int LAT   = 3;
  localparam int BURST = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [BW-1:0] wr_data_hi, wr_data_lo;
  logic          rd_req;
  logic [7:0]    rd_len;
  logic          rd_ack, rd_valid, rd_done;
  logic [BW-1:0] rd_data_hi, rd_data_lo;
  logic          gpio_oe;
  logic [BW-1:0] gpio_out_hi, gpio_out_lo;
  logic [BW-1:0] gpio_in_hi, gpio_in_lo;
  logic          busy;

  gpio_bus_turnaround_ctrl #(
    .BUS_WIDTH(BW), .TA_CYCLES(TA), .IN_LAT(LAT), .MAX_BURST(BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data_hi(wr_data_hi), .wr_data_lo(wr_data_lo),
    .rd_req(rd_req), .rd_len(rd_len), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data_hi(rd_data_hi), .rd_data_lo(rd_data_lo),
    .rd_done(rd_done),
    .gpio_oe(gpio_oe), .gpio_out_hi(gpio_out_hi), .gpio_out_lo(gpio_out_lo),
    .gpio_in_hi(gpio_in_hi), .gpio_in_lo(gpio_in_lo),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle index: during cycle c (between posedge c and c+1) cyc == c.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // GPIO input path model: a distinct value every cycle, so any latency
  // error shows up as wrong data.
  function automatic logic [7:0] f_hi(input int c);
    return 8'(c * 7 + 19);
  endfunction
  function automatic logic [7:0] f_lo(input int c);
    return 8'(c * 13 + 101);
  endfunction
  assign gpio_in_hi = f_hi(cyc);
  assign gpio_in_lo = f_lo(cyc);

  typedef struct { logic [7:0] hi; logic [7:0] lo; } wr_exp_t;
  typedef struct { int cyc; logic [7:0] hi; logic [7:0] lo; logic done; } rd_exp_t;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model state (transaction level).
  bit m_dir;        // 1 = bus last driven by us (TX), 0 = RX
  bit m_last;       // 1 = last grant was write
  int m_idle_from;  // first cycle in which the controller can arbitrate

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  bit prev_beat = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_beat = 1'b0;
    end else begin
      if (prev_beat) begin
        if (wr_q.size() == 0) check("wr_unexpected_beat", 1, 0);
        else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("gpio_out", {gpio_oe, gpio_out_hi, gpio_out_lo}, {1'b1, e.hi, e.lo});
        end
      end
      prev_beat = wr_valid && wr_ready;

      if (rd_valid) begin
        if (rd_q.size() == 0) check("rd_extra_beat", 1, 0);
        else begin
          rd_exp_t r;
          r = rd_q.pop_front();
          check("rd_beat", {cyc, rd_data_hi, rd_data_lo, rd_done},
                {r.cyc, r.hi, r.lo, r.done});
        end
      end else begin
        if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
          void'(rd_q.pop_front());
          check("rd_missing_beat", 0, 1);
        end
        if (rd_done) check("rd_done_without_valid", 1, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic reset_hold();
    rst_n = 1'b0;
    wr_valid = 1'b0;
    rd_req = 1'b0;
    wr_q.delete();
    rd_q.delete();
    repeat (2) tick();
    check("reset_values",
          {gpio_oe, wr_ready, rd_ack, rd_valid, rd_done, busy,
           gpio_out_hi, gpio_out_lo, rd_data_hi, rd_data_lo}, 0);
    rst_n = 1'b1;
    m_dir = 1'b0;
    m_last = 1'b0;
    m_idle_from = cyc;
  endtask

  task automatic do_write(input int n, input logic [7:0] bh, input logic [7:0] bl);
    int g, exp_first, waited;
    bit oe_bad;
    wr_valid = 1'b1;
    wr_data_hi = bh;
    wr_data_lo = bl;
    g = imax(cyc, m_idle_from);
    exp_first = g + 1 + (m_dir ? 0 : TA);
    waited = 0;
    oe_bad = 1'b0;
    while (!wr_ready && waited < 300) begin
      if (gpio_oe !== m_dir) oe_bad = 1'b1;
      tick();
      waited++;
    end
    check("wr_start_cycle", cyc, exp_first);
    check("wr_wait_oe", oe_bad, 0);
    for (int i = 0; i < n; i++) begin
      wr_data_hi = bh + 8'(i);
      wr_data_lo = bl + 8'(i);
      check("wr_ready_hold", wr_ready, 1);
      wr_q.push_back('{hi: wr_data_hi, lo: wr_data_lo});
      tick();
    end
    wr_valid = 1'b0;
    m_idle_from = cyc + 1;
    m_dir = 1'b1;
    m_last = 1'b1;
    tick();
  endtask

  // Called in the rd_ack cycle; returns in the first IDLE cycle after RX.
  task automatic read_body(input logic [7:0] len);
    int a, ta, l;
    bit oe_bad, ack_bad;
    a = cyc;
    ta = m_dir ? TA : 0;
    l = (len == 8'd0) ? 256 : int'(len);
    for (int i = 0; i < l; i++) begin
      int s;
      s = a + ta + i;
      rd_q.push_back('{cyc: s + LAT + 1, hi: f_hi(s + LAT), lo: f_lo(s + LAT),
                      done: (i == l - 1)});
    end
    oe_bad = 1'b0;
    ack_bad = 1'b0;
    for (int i = 0; i < ta + l; i++) begin
      if (gpio_oe !== 1'b0) oe_bad = 1'b1;
      if (i > 0 && rd_ack !== 1'b0) ack_bad = 1'b1;
      tick();
    end
    check("rd_oe_low", oe_bad, 0);
    check("rd_ack_pulse", ack_bad, 0);
    m_idle_from = cyc;
    m_dir = 1'b0;
    m_last = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] len);
    int g, waited;
    rd_req = 1'b1;
    rd_len = len;
    g = imax(cyc, m_idle_from);
    waited = 0;
    while (!rd_ack && waited < 600) begin
      tick();
      waited++;
    end
    check("rd_ack_cycle", cyc, g + 1);
    check("busy_in_read", busy, 1);
    rd_req = 1'b0;
    read_body(len);
  endtask

  // Both requesters held high: grants must alternate, write first after reset.
  task automatic contention(input int grants, input logic [7:0] len);
    int g, waited, beats;
    wr_valid = 1'b1;
    rd_req = 1'b1;
    rd_len = len;
    for (int k = 0; k < grants; k++) begin
      g = imax(cyc, m_idle_from);
      if (!m_last) begin
        waited = 0;
        while (!wr_ready && waited < 600) begin
          tick();
          waited++;
        end
        check("cont_wr_start", cyc, g + 1 + (m_dir ? 0 : TA));
        beats = 0;
        while (beats < 300) begin
          wr_data_hi = 8'($urandom);
          wr_data_lo = 8'($urandom);
          if (!wr_ready) break;
          wr_q.push_back('{hi: wr_data_hi, lo: wr_data_lo});
          beats++;
          tick();
        end
        check("cont_burst_len", beats, BURST);
        m_idle_from = cyc;
        m_dir = 1'b1;
        m_last = 1'b1;
      end else begin
        waited = 0;
        while (!rd_ack && waited < 600) begin
          tick();
          waited++;
        end
        check("cont_rd_ack", cyc, g + 1);
        read_body(len);
      end
    end
    wr_valid = 1'b0;
    rd_req = 1'b0;
    tick();
  endtask

  task automatic mid_tx_reset();
    int waited;
    wr_valid = 1'b1;
    wr_data_hi = 8'h11;
    wr_data_lo = 8'h22;
    waited = 0;
    while (!wr_ready && waited < 600) begin
      tick();
      waited++;
    end
    wr_q.push_back('{hi: 8'h11, lo: 8'h22});
    tick();
    wr_data_hi = 8'h12;
    wr_data_lo = 8'h23;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_oe_ready", {gpio_oe, wr_ready}, 0);
    reset_hold();
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && waited < 1000) begin
      tick();
      waited++;
    end
    check("drain_queues", rd_q.size() + wr_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_data_hi = '0;
    wr_data_lo = '0;
    rd_req = 1'b0;
    rd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_hold();

    do_write(4, 8'hA0, 8'h50);
    do_read(8'd3);
    drain();
    do_read(8'd0);
    drain();

    do_write(3, 8'h10, 8'h20);
    do_write(5, 8'h30, 8'h40);
    drain();

    reset_hold();
    contention(4, 8'd5);
    drain();

    mid_tx_reset();
    do_write(2, 8'hC0, 8'hD0);

    repeat (25) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(1, 8), 8'($urandom), 8'($urandom));
      else
        do_read(8'($urandom_range(1, 24)));
    end

    drain();
    repeat (2) tick();
    check("busy_idle_end", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gpio_bus_turnaround_ctrl.md
Name: gpio_bus_turnaround_ctrl

Overview:
- Sequences a shared half-duplex bidirectional DDIO GPIO bus between one write requester and one read requester.
- Drives the GPIO block's out_HI/out_LO/oe inputs and consumes its in_HI/in_LO outputs.
- Inserts bus-turnaround idle cycles on every direction change.
- Round-robin arbitrates when both requesters are pending, and tracks input-path latency so read data returns tagged valid.

Parameters:
- BUS_WIDTH, 8: GPIO data width per DDIO phase.
- TA_CYCLES, 2: oe-low cycles inserted on each direction change; legal range 1..15.
- IN_LAT, 3: cycles from sample strobe to data valid at gpio_in_* (input reg + LO resync + board); legal range 1..7.
- MAX_BURST, 16: maximum write beats per grant while rd_req is pending; legal range 1..255.

Ports:
- clk, in, 1: single clock; GPIO outclk/inclk are driven from it.
- rst_n, in, 1: asynchronous active-low reset.
- wr_valid, in, 1: write beat available.
- wr_ready, out, 1: write beat accepted when wr_valid & wr_ready.
- wr_data_hi, in, BUS_WIDTH: rising-edge data for the beat.
- wr_data_lo, in, BUS_WIDTH: falling-edge data for the beat.
- rd_req, in, 1: read request, level, held until rd_ack.
- rd_len, in, 8: beats to read; 0 means 256; sampled on rd_ack.
- rd_ack, out, 1: one-cycle pulse on read grant.
- rd_valid, out, 1: read beat valid.
- rd_data_hi, out, BUS_WIDTH: captured rising-edge data.
- rd_data_lo, out, BUS_WIDTH: captured falling-edge data.
- rd_done, out, 1: one-cycle pulse with the last rd_valid of a read.
- gpio_oe, out, 1: to GPIO oe.
- gpio_out_hi, out, BUS_WIDTH: to GPIO out_HI.
- gpio_out_lo, out, BUS_WIDTH: to GPIO out_LO.
- gpio_in_hi, in, BUS_WIDTH: from GPIO in_HI.
- gpio_in_lo, in, BUS_WIDTH: from GPIO in_LO.
- busy, out, 1: state != IDLE or read pipeline not drained.

Behaviour:
- Reset is asynchronous on rst_n low. Takes effect immediately, including mid-burst.
- Reset values: gpio_oe=0, gpio_out_*=0, wr_ready=0, rd_ack=0, rd_valid=0, rd_done=0, rd_data_*=0, busy=0.
- Reset internal state: state=IDLE, dir=RX (bus treated as externally driven), last_grant=RD (write wins the first tie), all counters 0, strobe pipeline cleared.
- All outputs are registered except wr_ready, which is 1 exactly when state==TX.
- States: IDLE, TA, TX, RX.
- IDLE, arbitration:
  - Only wr_valid set: grant WR.
  - Only rd_req set: grant RD.
  - Both set: grant the opposite of last_grant.
  - On RD grant: pulse rd_ack, latch rd_len.
  - If the granted direction differs from dir: go to TA, load TA counter = TA_CYCLES, set gpio_oe=0.
  - Otherwise go straight to TX or RX.
- TA:
  - gpio_oe held 0.
  - Counter decrements each cycle; on reaching 0, go to the granted state and update dir.
  - Requests are not re-arbitrated during TA.
- TX:
  - Each accepted beat registers wr_data_hi/lo onto gpio_out_hi/lo and sets gpio_oe=1 at the same edge.
  - gpio_out_* hold their last value on cycles with no beat.
  - Beat counter increments per beat.
  - Exit to IDLE when wr_valid=0, or when count==MAX_BURST and rd_req=1.
  - On exit: last_grant=WR, counter cleared.
  - gpio_oe stays 1 in IDLE while dir=TX; it drops only on entering TA.
- RX:
  - gpio_oe=0.
  - One sample strobe per cycle, for the latched length, into an IN_LAT-deep shift register.
  - A strobe emerging from the shift register registers gpio_in_hi/lo into rd_data_* with rd_valid=1.
  - The strobe that was last of the read also pulses rd_done.
  - After the last strobe is issued: go to IDLE, last_grant=RD.
  - The pipeline drains independently. A following TA/TX may overlap the drain, so rd_valid can assert while gpio_oe=1.
- Simultaneous events: a new rd_req during TX is honoured only after the burst ends. A write arriving at the same cycle TX exits waits for the next IDLE arbitration (one IDLE cycle minimum between grants).
- Width rules: beat counter 8 bits; read length counter 9 bits (256 representable); TA counter 4 bits; wrap-around is impossible within the legal ranges.

Test Plan:
- Reset, then 4-beat write (hi=8'hA0+i, lo=8'h50+i):
  - 1 IDLE cycle, 2 TA cycles with gpio_oe=0, then wr_ready=1 for 4 cycles.
  - gpio_oe=1 from the edge of the first beat; gpio_out_hi sequence A0..A3.
- Read rd_len=3 after the write:
  - rd_ack pulse, 2 TA cycles with gpio_oe=0, 3 strobes.
  - rd_valid on 3 cycles exactly IN_LAT=3 cycles after each strobe; rd_data matches bench-driven gpio_in; rd_done with the third.
- rd_len=0: exactly 256 rd_valid pulses, rd_done on the 256th.
- wr_valid and rd_req both held high:
  - Write granted first, stops after exactly 16 beats.
  - Read follows, then write again (round-robin alternation), with TA between each.
- Back-to-back writes with no direction change: second grant enters TX with no TA cycles; gpio_oe stays 1 throughout.
- rst_n low in the middle of TX beat 2: gpio_oe=0 and wr_ready=0 immediately, without waiting for a clock. After release, the next write incurs the full TA again.
